div_arbiter: RTL and testbench

Round-robin scheduler that shares one multi-cycle divider among NREQ polyphony controllers. Each controller holds its `start` level while waiting for a division. The arbiter grants one requester at a time, issues a single start pulse to the divider, and waits for the divider's done strobe. It then returns a one-cycle `ready` pulse to the granted controller. It sits between the poly_ctrl instances and the shared divider, and drives the operand mux select.

---
 rtl/div_arbiter_pkg.sv | 16 +
 rtl/div_arbiter_if.sv | 32 +++
 rtl/div_arbiter_rr_picker.sv | 24 ++
 rtl/div_arbiter.sv | 139 +++++++++++++
 tb/tb_div_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_arbiter_pkg.sv
// rtl/div_arbiter_pkg.sv - shared types and default constants for the divider arbiter
package div_arb_pkg;

    // Arbiter FSM: wait for a request, pulse the divider, wait for its result, release requester
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } div_arb_state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_OSC_W   = 6;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/div_arbiter_if.sv
// rtl/div_arbiter_if.sv - requester/divider bundle between poly_ctrl instances, arbiter and divider
interface div_arbiter_if
    import div_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int OSC_W = DEF_OSC_W
);
    localparam int SEL_W = $clog2(NREQ);

    logic [NREQ-1:0]            req;
    logic [NREQ-1:0][OSC_W-1:0] req_osc_num;
    logic                       div_done;
    logic                       div_start;
    logic [SEL_W-1:0]           sel;
    logic [OSC_W-1:0]           div_osc_num;
    logic [NREQ-1:0]            gnt_ready;
    logic                       busy;
    logic                       err;

    // Arbiter side
    modport master (
        input  req, req_osc_num, div_done,
        output div_start, sel, div_osc_num, gnt_ready, busy, err
    );

    // Requester/divider side
    modport slave (
        output req, req_osc_num, div_done,
        input  div_start, sel, div_osc_num, gnt_ready, busy, err
    );

endinterface

// File: rtl/div_arbiter_rr_picker.sv
// rtl/div_arbiter_rr_picker.sv - combinational round-robin winner search starting after last
module rr_picker #(
    parameter int NREQ  = 4,
    parameter int SEL_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic             any_req,
    output logic [SEL_W-1:0] winner
);

    // Scan offsets from farthest to nearest so the nearest set request after last overwrites the rest
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[(int'(last) + i) % NREQ]) begin
                any_req = 1'b1;
                winner  = SEL_W'((int'(last) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin sharing of one divider; optional watchdog under DIV_ARB_TIMEOUT_EN
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int OSC_W   = DEF_OSC_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    div_arbiter_if.master bus
);

    localparam int SEL_W = $clog2(NREQ);

    div_arb_state_t   state_q, state_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [OSC_W-1:0] osc_q, osc_d;
    logic             div_start_q, div_start_d;
    logic [NREQ-1:0]  gnt_ready_q, gnt_ready_d;
    logic             busy_q, busy_d;

    logic             any_req;
    logic [SEL_W-1:0] winner;
    logic             timeout;

    rr_picker #(
        .NREQ  (NREQ),
        .SEL_W (SEL_W)
    ) u_picker (
        .req     (bus.req),
        .last    (last_q),
        .any_req (any_req),
        .winner  (winner)
    );

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Watchdog: restart at ISSUE, count WAIT cycles; a real div_done in the same cycle wins
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        timeout = (state_q == WAIT) && !bus.div_done && (cnt_d == CNT_W'(TIMEOUT));
        err_d   = err_q | timeout;
    end

    // Watchdog counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout = 1'b0;
    // No watchdog: err is constant 0 for any legal (positive) TIMEOUT
    assign bus.err = (TIMEOUT < 0);
`endif

    // Next state, grant latch and round-robin pointer update
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        osc_d   = osc_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                    sel_d   = winner;
                    osc_d   = bus.req_osc_num[winner];
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.div_done || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = sel_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state
    always_comb begin
        div_start_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
        gnt_ready_d = '0;
        if (state_d == RESP) begin
            gnt_ready_d[sel_d] = 1'b1;
        end
    end

    // State, pointer, grant latches and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= SEL_W'(NREQ - 1);
            sel_q       <= '0;
            osc_q       <= '0;
            div_start_q <= 1'b0;
            gnt_ready_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            osc_q       <= osc_d;
            div_start_q <= div_start_d;
            gnt_ready_q <= gnt_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.div_start   = div_start_q;
    assign bus.sel         = sel_q;
    assign bus.div_osc_num = osc_q;
    assign bus.gnt_ready   = gnt_ready_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed vector bench for div_arbiter (NREQ=4, OSC_W=6, TIMEOUT=8)
module tb_div_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_arbiter_if #(.NREQ(4), .OSC_W(6)) bus ();

    div_arbiter #(
        .NREQ    (4),
        .OSC_W   (6),
        .TIMEOUT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic       start;
        logic [1:0] sel;
        logic [5:0] osc;
        logic [3:0] gnt;
        logic       busy;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[26];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic s, input logic [1:0] se,
                           input logic [5:0] o, input logic [3:0] g, input logic b);
        chk({tag, ".div_start"},   32'(bus.div_start),   32'(s));
        chk({tag, ".sel"},         32'(bus.sel),         32'(se));
        chk({tag, ".div_osc_num"}, 32'(bus.div_osc_num), 32'(o));
        chk({tag, ".gnt_ready"},   32'(bus.gnt_ready),   32'(g));
        chk({tag, ".busy"},        32'(bus.busy),        32'(b));
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic d, input logic s,
                                input logic [1:0] se, input logic [5:0] o,
                                input logic [3:0] g, input logic b);
        vec_t v;
        v.req = r; v.done = d; v.start = s; v.sel = se; v.osc = o; v.gnt = g; v.busy = b;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        logic [1:0] prev;

        // Inputs applied during one cycle; outputs expected after the following edge
        vecs[0]  = mk(4'b0100, 1'b0, 1'b1, 2'd2, 6'd9,  4'b0000, 1'b1);
        vecs[1]  = mk(4'b0100, 1'b0, 1'b0, 2'd2, 6'd9,  4'b0000, 1'b1);
        vecs[2]  = mk(4'b0100, 1'b0, 1'b0, 2'd2, 6'd9,  4'b0000, 1'b1);
        vecs[3]  = mk(4'b0100, 1'b0, 1'b0, 2'd2, 6'd9,  4'b0000, 1'b1);
        vecs[4]  = mk(4'b0100, 1'b0, 1'b0, 2'd2, 6'd9,  4'b0000, 1'b1);
        vecs[5]  = mk(4'b0100, 1'b0, 1'b0, 2'd2, 6'd9,  4'b0000, 1'b1);
        vecs[6]  = mk(4'b0100, 1'b1, 1'b0, 2'd2, 6'd9,  4'b0100, 1'b1);
        vecs[7]  = mk(4'b0100, 1'b0, 1'b0, 2'd2, 6'd9,  4'b0000, 1'b0);
        vecs[8]  = mk(4'b0000, 1'b1, 1'b0, 2'd2, 6'd9,  4'b0000, 1'b0);
        vecs[9]  = mk(4'b0001, 1'b1, 1'b1, 2'd0, 6'd3,  4'b0000, 1'b1);
        vecs[10] = mk(4'b0001, 1'b1, 1'b0, 2'd0, 6'd3,  4'b0000, 1'b1);
        vecs[11] = mk(4'b0001, 1'b0, 1'b0, 2'd0, 6'd3,  4'b0000, 1'b1);
        vecs[12] = mk(4'b0001, 1'b1, 1'b0, 2'd0, 6'd3,  4'b0001, 1'b1);
        vecs[13] = mk(4'b0000, 1'b0, 1'b0, 2'd0, 6'd3,  4'b0000, 1'b0);
        vecs[14] = mk(4'b1001, 1'b0, 1'b1, 2'd3, 6'd12, 4'b0000, 1'b1);
        vecs[15] = mk(4'b1001, 1'b0, 1'b0, 2'd3, 6'd12, 4'b0000, 1'b1);
        vecs[16] = mk(4'b1001, 1'b1, 1'b0, 2'd3, 6'd12, 4'b1000, 1'b1);
        vecs[17] = mk(4'b1001, 1'b0, 1'b0, 2'd3, 6'd12, 4'b0000, 1'b0);
        vecs[18] = mk(4'b1001, 1'b0, 1'b1, 2'd0, 6'd3,  4'b0000, 1'b1);
        vecs[19] = mk(4'b1001, 1'b0, 1'b0, 2'd0, 6'd3,  4'b0000, 1'b1);
        vecs[20] = mk(4'b1001, 1'b1, 1'b0, 2'd0, 6'd3,  4'b0001, 1'b1);
        vecs[21] = mk(4'b0000, 1'b0, 1'b0, 2'd0, 6'd3,  4'b0000, 1'b0);
        vecs[22] = mk(4'b0010, 1'b0, 1'b1, 2'd1, 6'd5,  4'b0000, 1'b1);
        vecs[23] = mk(4'b0000, 1'b0, 1'b0, 2'd1, 6'd5,  4'b0000, 1'b1);
        vecs[24] = mk(4'b0000, 1'b1, 1'b0, 2'd1, 6'd5,  4'b0010, 1'b1);
        vecs[25] = mk(4'b0000, 1'b0, 1'b0, 2'd1, 6'd5,  4'b0000, 1'b0);

        rst = 1'b1;
        bus.req = 4'b0000;
        bus.div_done = 1'b0;
        bus.req_osc_num[0] = 6'd3;
        bus.req_osc_num[1] = 6'd5;
        bus.req_osc_num[2] = 6'd9;
        bus.req_osc_num[3] = 6'd12;

        tick();
        tick();
        chk_out("reset", 1'b0, 2'd0, 6'd0, 4'b0000, 1'b0);
        chk("reset.err", 32'(bus.err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            bus.req = vecs[i].req;
            bus.div_done = vecs[i].done;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].start, vecs[i].sel, vecs[i].osc,
                    vecs[i].gnt, vecs[i].busy);
        end
        bus.req = 4'b0000;
        bus.div_done = 1'b0;

        // Reset held with every requester asking: nothing may start
        rst = 1'b1;
        bus.req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out($sformatf("rst_hold%0d", c), 1'b0, 2'd0, 6'd0, 4'b0000, 1'b0);
        end
        rst = 1'b0;
        tick();
        chk("rel.div_start", 32'(bus.div_start), 32'd1);
        chk("rel.sel", 32'(bus.sel), 32'd0);

        // Fairness: all requesters held, grants must rotate
        prev = 2'd3;
        for (int t = 0; t < 8; t++) begin
            n = 0;
            while (bus.div_start !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("fair%0d.start_seen", t), 32'(bus.div_start), 32'd1);
            chk($sformatf("fair%0d.sel", t), 32'(bus.sel), 32'(t % 4));
            if (t > 0) begin
                chk($sformatf("fair%0d.no_repeat", t), 32'(bus.sel != prev), 32'd1);
            end
            prev = bus.sel;
            tick();
            bus.div_done = 1'b1;
            tick();
            bus.div_done = 1'b0;
            chk($sformatf("fair%0d.gnt", t), 32'(bus.gnt_ready), 32'(1 << (t % 4)));
        end
        bus.req = 4'b0000;
        tick();
        tick();

        // Reset in the middle of WAIT
        bus.req = 4'b0010;
        tick();
        chk("mid.issue_sel", 32'(bus.sel), 32'd1);
        tick();
        tick();
        chk("mid.wait_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_out("mid.async", 1'b0, 2'd0, 6'd0, 4'b0000, 1'b0);
        bus.req = 4'b0011;
        tick();
        rst = 1'b0;
        bus.div_done = 1'b1;
        tick();
        chk_out("mid.regrant", 1'b1, 2'd0, 6'd3, 4'b0000, 1'b1);
        tick();
        chk_out("mid.late_done", 1'b0, 2'd0, 6'd3, 4'b0000, 1'b1);
        bus.div_done = 1'b0;
        tick();
        bus.div_done = 1'b1;
        tick();
        bus.div_done = 1'b0;
        bus.req = 4'b0000;
        chk("mid.gnt", 32'(bus.gnt_ready), 32'b0001);
        tick();

        // Divider never answers
        bus.req = 4'b0100;
        tick();
        chk("wd.start", 32'(bus.div_start), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("wd.wait%0d.gnt", c), 32'(bus.gnt_ready), 32'd0);
        end
        tick();
`ifdef DIV_ARB_TIMEOUT_EN
        chk("wd.release", 32'(bus.gnt_ready), 32'b0100);
        chk("wd.err", 32'(bus.err), 32'd1);
        bus.req = 4'b0000;
        tick();
        bus.div_done = 1'b1;
        tick();
        bus.div_done = 1'b0;
        chk("wd.late_gnt", 32'(bus.gnt_ready), 32'd0);
        chk("wd.late_busy", 32'(bus.busy), 32'd0);
        tick();
        tick();
        chk("wd.err_sticky", 32'(bus.err), 32'd1);
`else
        chk("wd.no_release", 32'(bus.gnt_ready), 32'd0);
        chk("wd.err_zero", 32'(bus.err), 32'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
        end
        chk("wd.still_busy", 32'(bus.busy), 32'd1);
        chk("wd.still_no_gnt", 32'(bus.gnt_ready), 32'd0);
        bus.div_done = 1'b1;
        tick();
        bus.div_done = 1'b0;
        bus.req = 4'b0000;
        chk("wd.final_gnt", 32'(bus.gnt_ready), 32'b0100);
        chk("wd.final_err", 32'(bus.err), 32'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
